serial_addsub_seq: RTL

//   Bit-serial WIDTH-bit adder/subtractor built around one 1-bit full add/sub cell.
//   A sequencer feeds the cell one bit pair per clock, LSB first, with a registered carry.

---
 rtl/serial_addsub_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/serial_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_addsub_seq
// Description : Bit-serial WIDTH-bit adder/subtractor built around a single
//               1-bit full add/sub cell. Operands are consumed LSB first, one
//               bit pair per clock, with the carry held in a register.
//               Mode = 0 computes A+B, Mode = 1 computes A-B (two's complement).
//               The handshake is start/busy/done.
// Ports       :
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      request; sampled only in IDLE
//   Mode   in   1      0 = add, 1 = subtract; captured with the operands
//   A, B   in   WIDTH  operands; captured on the accepting edge
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when Sum/Cout/ovf are updated
//   Sum    out  WIDTH  result, held until the next completion
//   Cout   out  1      add: carry out; sub: borrow (A < B unsigned)
//   ovf    out  1      signed overflow of the selected operation
// Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] c_last_bit = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_areg;
    logic [WIDTH-1:0] r_breg;
    logic [WIDTH-1:0] r_shift;
    logic             r_carry;
    logic             r_mode;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic             w_s;
    logic             w_carry_out;
    logic [WIDTH-1:0] w_shift_next;

    // The single full add/sub cell. Subtraction is handled upstream by
    // inverting B at capture and seeding the carry with 1.
    assign w_s          = r_areg[0] ^ r_breg[0] ^ r_carry;
    assign w_carry_out  = (r_areg[0] & r_breg[0]) | (r_carry & (r_areg[0] ^ r_breg[0]));
    // Result bits enter from the MSB side so the LSB ends up at bit 0
    // after WIDTH shifts.
    assign w_shift_next = {w_s, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_areg  <= '0;
            r_breg  <= '0;
            r_shift <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_areg  <= A;
                        r_breg  <= B ^ {WIDTH{Mode}};
                        r_mode  <= Mode;
                        r_carry <= Mode;
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_shift <= w_shift_next;
                    r_carry <= w_carry_out;
                    r_areg  <= r_areg >> 1;
                    r_breg  <= r_breg >> 1;
                    if (r_cnt == c_last_bit) begin
                        r_sum   <= w_shift_next;
                        // In subtract mode the raw carry is "no borrow";
                        // flip it so Cout reads as a borrow.
                        r_cout  <= w_carry_out ^ r_mode;
                        // r_carry is the carry into the MSB on this edge.
                        r_ovf   <= r_carry ^ w_carry_out;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
